// File: rtl/pipelined_prefix_adder_if.sv
// Operand/result handshake bundle for the pipelined prefix adder.
// The slave modport is the adder. The master modport is whatever drives operands and consumes results.
interface pipelined_prefix_adder_if #(parameter int WIDTH = 8);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );
endinterface

// File: rtl/pipelined_prefix_adder.sv
// Kogge-Stone adder/subtractor with a register after operand prep and after every prefix level.
// A single global stall freezes the whole pipe when the result is not taken.
module pipelined_prefix_adder #(
    parameter  int WIDTH  = 8,
    localparam int LEVELS = $clog2(WIDTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    pipelined_prefix_adder_if.slave  bus
);
    logic [LEVELS:0]                  vld_q, vld_d;
    logic [LEVELS:0][WIDTH-1:0]       g_q, g_d;
    logic [LEVELS:0][WIDTH-1:0]       po_q, po_d;
    // The group-propagate vector is not needed after the last level.
    logic [LEVELS-1:0][WIDTH-1:0]     p_q, p_d;
    logic [LEVELS:0]                  c0_q, c0_d;
    logic [LEVELS:0]                  am_q, am_d;
    logic [LEVELS:0]                  bm_q, bm_d;
    logic [WIDTH-1:0]                 bb;
    logic [WIDTH-1:0]                 sum_w;
    logic                             stall;

    assign stall = vld_q[LEVELS] & ~bus.out_ready;
    assign bb    = bus.sub ? ~bus.b : bus.b;

    assign vld_d[0] = bus.in_valid;
    assign g_d[0]   = bus.a & bb;
    assign po_d[0]  = bus.a ^ bb;
    assign p_d[0]   = bus.a ^ bb;
    assign c0_d[0]  = bus.sub | bus.cin;
    assign am_d[0]  = bus.a[WIDTH-1];
    assign bm_d[0]  = bb[WIDTH-1];

    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        localparam int D = 1 << (k - 1);
        logic [WIDTH-1:0] gf;

        // Carry-in becomes part of bit 0's generate before the first combine.
        if (k == 1) begin : g_fold
            assign gf = {g_q[0][WIDTH-1:1], g_q[0][0] | (p_q[0][0] & c0_q[0])};
        end else begin : g_nofold
            assign gf = g_q[k-1];
        end

        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (i >= D) begin : g_comb
                assign g_d[k][i] = gf[i] | (p_q[k-1][i] & gf[i-D]);
            end else begin : g_pass
                assign g_d[k][i] = gf[i];
            end
            if (k < LEVELS) begin : g_prop
                if (i >= D) begin : g_pc
                    assign p_d[k][i] = p_q[k-1][i] & p_q[k-1][i-D];
                end else begin : g_pp
                    assign p_d[k][i] = p_q[k-1][i];
                end
            end
        end

        assign vld_d[k] = vld_q[k-1];
        assign po_d[k]  = po_q[k-1];
        assign c0_d[k]  = c0_q[k-1];
        assign am_d[k]  = am_q[k-1];
        assign bm_d[k]  = bm_q[k-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            g_q   <= '0;
            po_q  <= '0;
            p_q   <= '0;
            c0_q  <= '0;
            am_q  <= '0;
            bm_q  <= '0;
        end else if (!stall) begin
            vld_q <= vld_d;
            g_q   <= g_d;
            po_q  <= po_d;
            p_q   <= p_d;
            c0_q  <= c0_d;
            am_q  <= am_d;
            bm_q  <= bm_d;
        end
    end

    assign sum_w         = po_q[LEVELS] ^ {g_q[LEVELS][WIDTH-2:0], c0_q[LEVELS]};
    assign bus.sum       = sum_w;
    assign bus.cout      = g_q[LEVELS][WIDTH-1];
    assign bus.ovf       = (am_q[LEVELS] ~^ bm_q[LEVELS]) & (sum_w[WIDTH-1] ^ am_q[LEVELS]);
    // Held low in reset even though the cleared sum would otherwise read as zero.
    assign bus.zero      = rst_n & ~|sum_w;
    assign bus.out_valid = vld_q[LEVELS];
    assign bus.in_ready  = ~stall;
endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Directed checks on an 8-bit adder plus a randomised stream through a 13-bit adder.
// Expected values are hand-computed or come from a plain integer sum.
module tb_pipelined_prefix_adder;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    pipelined_prefix_adder_if #(.WIDTH(8))  i8 ();
    pipelined_prefix_adder_if #(.WIDTH(13)) i13 ();

    pipelined_prefix_adder #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(i8));
    pipelined_prefix_adder #(.WIDTH(13)) dut13 (.clk(clk), .rst_n(rst_n), .bus(i13));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send8(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic ci, input logic sb, input logic [7:0] es,
                         input logic ec, input logic eo, input logic ez);
        int lat;
        @(posedge clk); #1;
        i8.a = a; i8.b = b; i8.cin = ci; i8.sub = sb; i8.in_valid = 1'b1;
        @(posedge clk); #1;
        i8.in_valid = 1'b0;
        lat = 0;
        while (!i8.out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"},  64'(lat), 64'd3);
        chk({tag, "_sum"},  64'(i8.sum), 64'(es));
        chk({tag, "_cout"}, 64'(i8.cout), 64'(ec));
        chk({tag, "_ovf"},  64'(i8.ovf), 64'(eo));
        chk({tag, "_zero"}, 64'(i8.zero), 64'(ez));
    endtask

    typedef struct {
        logic [12:0] s;
        logic        c;
        logic        o;
        int          cyc;
        int          st;
    } exp_t;

    initial begin
        exp_t q[$];
        int   sent, rcv, cyc, stc, nstall, seen;
        logic held;
        logic [7:0] held_sum;

        rst_n = 1'b0;
        i8.in_valid = 0;  i8.a = '0;  i8.b = '0;  i8.cin = 0;  i8.sub = 0;  i8.out_ready = 1;
        i13.in_valid = 0; i13.a = '0; i13.b = '0; i13.cin = 0; i13.sub = 0; i13.out_ready = 1;

        #3;
        chk("rst_vld",  64'(i8.out_valid), 64'd0);
        chk("rst_sum",  64'(i8.sum), 64'd0);
        chk("rst_cout", 64'(i8.cout), 64'd0);
        chk("rst_ovf",  64'(i8.ovf), 64'd0);
        chk("rst_zero", 64'(i8.zero), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_inrdy", 64'(i8.in_ready), 64'd1);

        send8("ovf_add",  8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
        send8("sub_eq",   8'h05, 8'h05, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
        send8("sub_brw",  8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        send8("cin_rip",  8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        send8("sub_cin",  8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b0, 1'b0);
        send8("sub_ovf",  8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);

        // Back-pressure stream of six beats.
        sent = 0; rcv = 0; nstall = 0; held = 0; held_sum = '0;
        i8.cin = 0; i8.sub = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            i8.out_ready = !(c >= 4 && c <= 8);
            i8.in_valid  = (sent < 6);
            i8.a = 8'(sent + 1);
            i8.b = 8'(sent + 1);
            @(negedge clk);
            if (i8.out_valid && !i8.out_ready) begin
                nstall++;
                chk("bp_inrdy", 64'(i8.in_ready), 64'd0);
                if (held) chk("bp_hold", 64'(i8.sum), 64'(held_sum));
                held = 1; held_sum = i8.sum;
            end else begin
                held = 0;
            end
            if (i8.in_valid && i8.in_ready) sent++;
            if (i8.out_valid && i8.out_ready) begin
                chk("bp_seq", 64'(i8.sum), 64'(2 * (rcv + 1)));
                rcv++;
            end
        end
        i8.in_valid = 0; i8.out_ready = 1;
        chk("bp_count", 64'(rcv), 64'd6);
        chk("bp_stalled", 64'(nstall > 0), 64'd1);

        // Asynchronous reset with three beats in flight.
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            i8.in_valid = 1; i8.a = 8'h11; i8.b = 8'h22;
        end
        @(posedge clk); #1;
        i8.in_valid = 0;
        @(posedge clk); #1;
        chk("mid_pre_vld", 64'(i8.out_valid), 64'd1);
        chk("mid_pre_sum", 64'(i8.sum), 64'h33);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_vld",  64'(i8.out_valid), 64'd0);
        chk("mid_sum",  64'(i8.sum), 64'd0);
        chk("mid_zero", 64'(i8.zero), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (i8.out_valid) seen++;
        end
        chk("mid_stale", 64'(seen), 64'd0);

        // Random stream through the 13-bit instance with random back-pressure.
        sent = 0; rcv = 0; cyc = 0; stc = 0;
        while (rcv < 2000 && cyc < 8000) begin
            @(posedge clk); #1;
            i13.out_ready = ($urandom_range(0, 3) != 0);
            if (sent < 2000) begin
                i13.in_valid = 1;
                i13.a   = 13'($urandom);
                i13.b   = 13'($urandom);
                i13.cin = 1'($urandom);
            end else begin
                i13.in_valid = 0;
            end
            @(negedge clk);
            if (i13.out_valid && i13.out_ready) begin
                if (q.size() == 0) begin
                    chk("r_extra", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("r_sum",  64'(i13.sum), 64'(e.s));
                    chk("r_cout", 64'(i13.cout), 64'(e.c));
                    chk("r_ovf",  64'(i13.ovf), 64'(e.o));
                    chk("r_lat",  64'(cyc - e.cyc - 1 - (stc - e.st)), 64'd4);
                end
                rcv++;
            end
            if (i13.in_valid && i13.in_ready) begin
                exp_t e;
                logic [13:0] t;
                t = {1'b0, i13.a} + {1'b0, i13.b} + 14'(i13.cin);
                e.s = t[12:0];
                e.c = t[13];
                e.o = (i13.a[12] == i13.b[12]) && (t[12] != i13.a[12]);
                e.cyc = cyc;
                e.st  = stc;
                q.push_back(e);
                sent++;
            end
            if (i13.out_valid && !i13.out_ready) stc++;
            cyc++;
        end
        i13.in_valid = 0;
        chk("r_count", 64'(rcv), 64'd2000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
